shift_reg: RTL and testbench

SHIFT_REG -- requirements
Module: shift_reg

---
 rtl/shift_reg_pkg.sv | 11 +
 rtl/shift_reg_if.sv | 14 +
 rtl/shift_reg.sv | 51 +++++
 tb/tb_shift_reg.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode select encodings.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SHR  = 2'b01,
    SHL  = 2'b10,
    LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/shift_reg_if.sv
// Bundle of the shift register's data/control signals for system-level wiring.
interface shift_reg_if #(
  parameter int size = 8
);
  logic [1:0]      mode;
  logic [size-1:0] prl_in;
  logic            srl_in;
  logic [size-1:0] out;
  logic            srl_out;

  // master drives operations, slave is the register itself
  modport master (output mode, output prl_in, output srl_in, input out, input srl_out);
  modport slave  (input mode, input prl_in, input srl_in, output out, output srl_out);
endinterface

// File: rtl/shift_reg.sv
// Universal shift register: hold, shift right, shift left, parallel load, with
// a registered copy of the last bit shifted out.
module shift_reg
  import shift_reg_pkg::*;
#(
  parameter int size = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      mode,
  input  logic [size-1:0] prl_in,
  input  logic            srl_in,
  output logic [size-1:0] out,
  output logic            srl_out
);

  logic [size-1:0] out_q, out_d;
  logic            srl_q, srl_d;

  always_comb begin
    out_d = out_q;
    srl_d = srl_q;
    case (mode)
      SHR: begin
        out_d = {srl_in, out_q[size-1:1]};
        srl_d = out_q[0];
      end
      SHL: begin
        out_d = {out_q[size-2:0], srl_in};
        srl_d = out_q[size-1];
      end
      // a load replaces the contents but leaves the last shifted-out bit alone
      LOAD: out_d = prl_in;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      srl_q <= 1'b0;
    end else begin
      out_q <= out_d;
      srl_q <= srl_d;
    end
  end

  assign out     = out_q;
  assign srl_out = srl_q;

endmodule

// File: tb/tb_shift_reg.sv
// Self-checking bench for shift_reg (size=8) using an expected-value scoreboard.
module tb_shift_reg;
  import shift_reg_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] o;
    logic         s;
    string        name;
  } exp_t;

  logic clk;
  logic rst;
  shift_reg_if #(.size(W)) bus ();

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  shift_reg #(.size(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (bus.mode),
    .prl_in  (bus.prl_in),
    .srl_in  (bus.srl_in),
    .out     (bus.out),
    .srl_out (bus.srl_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation, let one rising edge happen, return 1 time unit after it.
  task automatic drive(input logic r, input logic [1:0] m, input logic [W-1:0] p, input logic s);
    rst        = r;
    bus.mode   = m;
    bus.prl_in = p;
    bus.srl_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] o, input logic s, input string name);
    exp_t e;
    e.o = o; e.s = s; e.name = name;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    logic [W-1:0] pv [3] = '{8'hFF, 8'h00, 8'h00};
    logic [1:0]   mv [3] = '{LOAD, HOLD, SHR};
    logic         rv [3] = '{1'b1, 1'b0, 1'b0};
    logic [W-1:0] eo [3] = '{8'h00, 8'h00, 8'h80};
    for (int i = 0; i < 3; i++) begin
      push(eo[i], 1'b0, $sformatf("reset_%0d", i));
      drive(rv[i], mv[i], pv[i], 1'b1);
      e = sb.pop_front();
      n_cmp++;
      $display("txn %s: out=%h srl_out=%b", e.name, bus.out, bus.srl_out);
      if (bus.out !== e.o || bus.srl_out !== e.s) begin
        n_err++;
        $display("FAIL %s: got out=%h srl_out=%b, want out=%h srl_out=%b",
                 e.name, bus.out, bus.srl_out, e.o, e.s);
      end
    end
  endtask

  task automatic test_load_hold();
    exp_t e;
    push(8'hAA, 1'b0, "load_aa");
    drive(1'b0, LOAD, 8'hAA, 1'b1);
    push(8'hAA, 1'b0, "hold_aa");
    drive(1'b0, HOLD, 8'h55, 1'b1);
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      n_cmp++;
      $display("txn %s: out=%h srl_out=%b", e.name, bus.out, bus.srl_out);
      if (bus.out !== e.o || bus.srl_out !== e.s) begin
        n_err++;
        $display("FAIL %s: got out=%h srl_out=%b, want out=%h srl_out=%b",
                 e.name, bus.out, bus.srl_out, e.o, e.s);
      end
      if (i == 0) begin
        // mid-cycle: contents must not move between edges
        #3;
        n_cmp++;
        if (bus.out !== 8'hAA) begin
          n_err++;
          $display("FAIL mid_cycle_stable: got out=%h, want out=aa", bus.out);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_shift(input logic [1:0] m, input string tag,
                            input logic [W-1:0] e1, input logic e1s,
                            input logic [W-1:0] e2, input logic e2s);
    exp_t e;
    push(e1, e1s, {tag, "_s1"});
    push(e2, e2s, {tag, "_s0"});
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, m, 8'h00, (i == 0) ? 1'b1 : 1'b0);
      e = sb.pop_front();
      n_cmp++;
      $display("txn %s: out=%h srl_out=%b", e.name, bus.out, bus.srl_out);
      if (bus.out !== e.o || bus.srl_out !== e.s) begin
        n_err++;
        $display("FAIL %s: got out=%h srl_out=%b, want out=%h srl_out=%b",
                 e.name, bus.out, bus.srl_out, e.o, e.s);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    drive(1'b0, LOAD, 8'hAA, 1'b0);
    push(8'h00, 1'b0, "rst_over_load");
    push(8'h00, 1'b0, "hold_after_rst");
    for (int i = 0; i < 2; i++) begin
      drive((i == 0), (i == 0) ? LOAD : HOLD, 8'hFF, 1'b1);
      e = sb.pop_front();
      n_cmp++;
      $display("txn %s: out=%h srl_out=%b", e.name, bus.out, bus.srl_out);
      if (bus.out !== e.o || bus.srl_out !== e.s) begin
        n_err++;
        $display("FAIL %s: got out=%h srl_out=%b, want out=%h srl_out=%b",
                 e.name, bus.out, bus.srl_out, e.o, e.s);
      end
    end
  endtask

  task automatic test_serial_fill();
    exp_t e;
    logic [W-1:0] ones = 8'hFF;
    for (int k = 1; k <= 2 * W; k++) begin
      if (k <= W) push(~(ones >> k), 1'b0, $sformatf("fill_r%0d", k));
      else        push(ones << (k - W), 1'b1, $sformatf("drain_l%0d", k - W));
      drive(1'b0, (k <= W) ? SHR : SHL, 8'h3C, (k <= W));
      e = sb.pop_front();
      n_cmp++;
      $display("txn %s: out=%h srl_out=%b", e.name, bus.out, bus.srl_out);
      if (bus.out !== e.o || bus.srl_out !== e.s) begin
        n_err++;
        $display("FAIL %s: got out=%h srl_out=%b, want out=%h srl_out=%b",
                 e.name, bus.out, bus.srl_out, e.o, e.s);
      end
    end
  endtask

  // Random back-to-back modes against a behavioural reference.
  task automatic test_back_to_back();
    exp_t e;
    logic [W-1:0] mo = '0;
    logic         ms = 1'b0;
    logic [1:0]   m;
    logic [W-1:0] p;
    logic         s, r;
    for (int i = 0; i < 60; i++) begin
      r = (i == 0) || ($urandom_range(0, 15) == 0);
      m = 2'($urandom_range(0, 3));
      p = 8'($urandom);
      s = 1'($urandom);
      if (r) begin
        mo = '0; ms = 1'b0;
      end else if (m == SHR) begin
        ms = mo[0]; mo = (mo >> 1) | ({{(W-1){1'b0}}, s} << (W - 1));
      end else if (m == SHL) begin
        ms = mo[W-1]; mo = (mo << 1) | {{(W-1){1'b0}}, s};
      end else if (m == LOAD) begin
        mo = p;
      end
      push(mo, ms, $sformatf("b2b_%0d_r%0b_m%0d", i, r, m));
      drive(r, m, p, s);
      e = sb.pop_front();
      n_cmp++;
      $display("txn %s: out=%h srl_out=%b", e.name, bus.out, bus.srl_out);
      if (bus.out !== e.o || bus.srl_out !== e.s) begin
        n_err++;
        $display("FAIL %s: got out=%h srl_out=%b, want out=%h srl_out=%b",
                 e.name, bus.out, bus.srl_out, e.o, e.s);
      end
    end
  endtask

  initial begin
    rst = 1'b1; bus.mode = HOLD; bus.prl_in = '0; bus.srl_in = 1'b0;
    test_reset();
    test_load_hold();
    test_shift(SHR, "shr", 8'hD5, 1'b0, 8'h6A, 1'b1);
    test_shift(SHL, "shl", 8'hD5, 1'b0, 8'hAA, 1'b1);
    test_reset_mid();
    test_serial_fill();
    test_back_to_back();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
